// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and a data-memory responder (slave).
// A request transfers on a rising edge where req_valid and req_ready are both high; rsp_valid is a one-cycle pulse.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: RISC-V byte/half/word loads and stores with fault flagging
// and a configurable number of wait states between accept and response.
module dmem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   dmem_responder_if.slave     bus,
   output logic [1:0]          dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t      state, next_state;
   logic [3:0]  cnt, next_cnt;
   logic        ready, accept, rsp_now, rsp_hold;
   logic [31:0] hold_rdata;
   logic        hold_err;
   logic [31:0] rsp_rdata_q;
   logic        rsp_valid_q, rsp_err_q;

   logic [31:0] mem [DEPTH];
   logic [AW-1:0] widx;
   logic [31:0] word, load, wlanes, acc_rdata;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [3:0]  be;
   logic        oor, bad, acc_err, wr_en;

   assign ready         = rst_n && (state != S_WAIT);
   assign accept        = bus.req_valid && ready;
   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign dbg_state     = state;

   assign widx     = bus.req_addr[AW+1:2];
   assign oor      = |bus.req_addr[31:AW+2];
   assign word     = mem[widx];
   assign byte_sel = word[8*bus.req_addr[1:0] +: 8];
   assign half_sel = bus.req_addr[1] ? word[31:16] : word[15:0];

   // Access decode: lane enables, replicated store data, extended load value and fault.
   always_comb begin
      load   = 32'd0;
      be     = 4'b0000;
      wlanes = bus.req_wdata;
      bad    = 1'b0;
      case (bus.req_funct3)
         3'b000: begin
            load   = {{24{byte_sel[7]}}, byte_sel};
            be     = 4'b0001 << bus.req_addr[1:0];
            wlanes = {4{bus.req_wdata[7:0]}};
         end
         3'b001: begin
            load   = {{16{half_sel[15]}}, half_sel};
            be     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{bus.req_wdata[15:0]}};
            bad    = bus.req_addr[0];
         end
         3'b010: begin
            load = word;
            be   = 4'b1111;
            bad  = |bus.req_addr[1:0];
         end
         3'b100: begin
            load = {24'd0, byte_sel};
            bad  = bus.req_we;
         end
         3'b101: begin
            load = {16'd0, half_sel};
            bad  = bus.req_we || bus.req_addr[0];
         end
         default: bad = 1'b1;
      endcase
      acc_err   = oor || bad;
      acc_rdata = (bus.req_we || acc_err) ? 32'd0 : load;
      wr_en     = accept && bus.req_we && !acc_err;
   end

   // Writes commit at the accept edge so a following load sees the new data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      rsp_now    = 1'b0;
      rsp_hold   = 1'b0;
      case (state)
         S_IDLE, S_RESP: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  next_state = S_RESP;
                  rsp_now    = 1'b1;
               end else begin
                  next_state = S_WAIT;
                  next_cnt   = WAIT_INIT;
               end
            end else begin
               next_state = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               next_state = S_RESP;
               rsp_hold   = 1'b1;
            end else begin
               next_cnt = cnt - 4'd1;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         hold_rdata  <= 32'd0;
         hold_err    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state       <= next_state;
         cnt         <= next_cnt;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         if (accept) begin
            hold_rdata <= acc_rdata;
            hold_err   <= acc_err;
         end
         if (rsp_now) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= acc_rdata;
            rsp_err_q   <= acc_err;
         end else if (rsp_hold) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= hold_rdata;
            rsp_err_q   <= hold_err;
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a zero-wait instance for data paths and faults,
// and a two-wait-state instance for stall timing and reset abandonment.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst_n0 = 1'b0;
   logic rst_n2 = 1'b0;
   logic [1:0] dbg0, dbg2;
   int checks = 0;
   int errors = 0;

   dmem_responder_if bus0 ();
   dmem_responder_if bus2 ();

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n0), .bus(bus0.slave), .dbg_state(dbg0));
   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n2), .bus(bus2.slave), .dbg_state(dbg2));

   always #5 clk = ~clk;

   // Present one request on the zero-wait instance; sample the response 1ns after the accept edge.
   task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic v, output logic [31:0] rd,
                       output logic e, output logic rdy);
      @(negedge clk);
      bus0.req_valid  = 1'b1;
      bus0.req_we     = we;
      bus0.req_addr   = addr;
      bus0.req_wdata  = wdata;
      bus0.req_funct3 = f3;
      #1 rdy = bus0.req_ready;
      @(posedge clk);
      #1;
      v  = bus0.rsp_valid;
      rd = bus0.rsp_rdata;
      e  = bus0.rsp_err;
      bus0.req_valid = 1'b0;
   endtask

   // Present one request on the two-wait instance; returns 1ns after the accept edge E0.
   task automatic req2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic rdy);
      @(negedge clk);
      bus2.req_valid  = 1'b1;
      bus2.req_we     = we;
      bus2.req_addr   = addr;
      bus2.req_wdata  = wdata;
      bus2.req_funct3 = f3;
      #1 rdy = bus2.req_ready;
      @(posedge clk);
      #1 bus2.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({bus0.rsp_valid, bus0.rsp_err, bus0.req_ready} !== 3'b000 || bus0.rsp_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b err=%b ready=%b rdata=%h, required 0 0 0 0",
                  bus0.rsp_valid, bus0.rsp_err, bus0.req_ready, bus0.rsp_rdata);
      end
      rst_n0 = 1'b1;
      rst_n2 = 1'b1;
      #1;
      checks++;
      if (bus0.req_ready !== 1'b1 || bus2.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: ready0=%b ready2=%b, required 1 1", bus0.req_ready, bus2.req_ready);
      end
   endtask

   task automatic test_word();
      logic v, e, rdy;
      logic [31:0] rd;
      req0(1'b1, 32'h80, 32'hFEEDF00D, 3'b010, v, rd, e, rdy);
      checks++;
      if ({v, e} !== 2'b10 || rd !== 32'd0) begin
         errors++;
         $display("FAIL sw_rsp: valid=%b err=%b rdata=%h, required 1 0 00000000", v, e, rd);
      end
      req0(1'b0, 32'h80, 32'h0, 3'b010, v, rd, e, rdy);
      checks++;
      if ({v, e, rdy} !== 3'b101 || rd !== 32'hFEEDF00D) begin
         errors++;
         $display("FAIL lw_after_sw: valid=%b err=%b ready=%b rdata=%h, required 1 0 1 feedf00d", v, e, rdy, rd);
      end
   endtask

   task automatic test_byte();
      logic v, e, rdy;
      logic [31:0] rd;
      req0(1'b1, 32'h81, 32'h000000A5, 3'b000, v, rd, e, rdy);
      checks++;
      if ({v, e} !== 2'b10 || rd !== 32'd0) begin
         errors++;
         $display("FAIL sb_rsp: valid=%b err=%b rdata=%h, required 1 0 00000000", v, e, rd);
      end
      req0(1'b0, 32'h81, 32'h0, 3'b000, v, rd, e, rdy);
      checks++;
      if (rd !== 32'hFFFFFFA5 || e !== 1'b0) begin
         errors++;
         $display("FAIL lb: rdata=%h err=%b, required ffffffa5 0", rd, e);
      end
      req0(1'b0, 32'h81, 32'h0, 3'b100, v, rd, e, rdy);
      checks++;
      if (rd !== 32'h000000A5 || e !== 1'b0) begin
         errors++;
         $display("FAIL lbu: rdata=%h err=%b, required 000000a5 0", rd, e);
      end
      req0(1'b0, 32'h80, 32'h0, 3'b010, v, rd, e, rdy);
      checks++;
      if (rd !== 32'hFEEDA50D) begin
         errors++;
         $display("FAIL lw_after_sb: rdata=%h, required feeda50d", rd);
      end
   endtask

   task automatic test_half();
      logic v, e, rdy;
      logic [31:0] rd;
      req0(1'b0, 32'h82, 32'h0, 3'b001, v, rd, e, rdy);
      checks++;
      if (rd !== 32'hFFFFFEED || e !== 1'b0) begin
         errors++;
         $display("FAIL lh: rdata=%h err=%b, required fffffeed 0", rd, e);
      end
      req0(1'b0, 32'h82, 32'h0, 3'b101, v, rd, e, rdy);
      checks++;
      if (rd !== 32'h0000FEED || e !== 1'b0) begin
         errors++;
         $display("FAIL lhu: rdata=%h err=%b, required 0000feed 0", rd, e);
      end
      req0(1'b1, 32'h80, 32'hABCD1234, 3'b001, v, rd, e, rdy);
      req0(1'b0, 32'h80, 32'h0, 3'b010, v, rd, e, rdy);
      checks++;
      if (rd !== 32'hFEED1234) begin
         errors++;
         $display("FAIL lw_after_sh: rdata=%h, required feed1234", rd);
      end
   endtask

   task automatic test_faults();
      logic v, e, rdy;
      logic [31:0] rd;
      req0(1'b0, 32'h82, 32'h0, 3'b010, v, rd, e, rdy);
      checks++;
      if ({v, e} !== 2'b11 || rd !== 32'd0) begin
         errors++;
         $display("FAIL lw_misaligned: valid=%b err=%b rdata=%h, required 1 1 00000000", v, e, rd);
      end
      req0(1'b1, 32'h83, 32'h00005555, 3'b001, v, rd, e, rdy);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL sh_misaligned: err=%b, required 1", e);
      end
      req0(1'b0, 32'h80, 32'h0, 3'b011, v, rd, e, rdy);
      checks++;
      if (e !== 1'b1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL funct3_011: err=%b rdata=%h, required 1 00000000", e, rd);
      end
      req0(1'b1, 32'h80, 32'h0, 3'b100, v, rd, e, rdy);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL store_bu: err=%b, required 1", e);
      end
      req0(1'b0, 32'd4096, 32'h0, 3'b010, v, rd, e, rdy);
      checks++;
      if (e !== 1'b1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL lw_out_of_range: err=%b rdata=%h, required 1 00000000", e, rd);
      end
      // 0x1080 would alias word 0x80 if the range check failed to block the write.
      req0(1'b1, 32'h1080, 32'h99999999, 3'b010, v, rd, e, rdy);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL sw_out_of_range: err=%b, required 1", e);
      end
      req0(1'b0, 32'h80, 32'h0, 3'b010, v, rd, e, rdy);
      checks++;
      if (rd !== 32'hFEED1234 || e !== 1'b0) begin
         errors++;
         $display("FAIL lw_after_faults: rdata=%h err=%b, required feed1234 0", rd, e);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus0.rsp_valid !== 1'b0 || dbg0 !== 2'd0) begin
         errors++;
         $display("FAIL idle_after_resp: valid=%b state=%0d, required 0 0", bus0.rsp_valid, dbg0);
      end
   endtask

   task automatic test_async_reset();
      logic v, e, rdy;
      logic [31:0] rd;
      req0(1'b0, 32'h80, 32'h0, 3'b010, v, rd, e, rdy);
      #2 rst_n0 = 1'b0;
      #1;
      checks++;
      if ({bus0.rsp_valid, bus0.req_ready} !== 2'b00 || bus0.rsp_rdata !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: valid=%b ready=%b rdata=%h, required 0 0 00000000",
                  bus0.rsp_valid, bus0.req_ready, bus0.rsp_rdata);
      end
      @(negedge clk);
      rst_n0 = 1'b1;
      req0(1'b0, 32'h80, 32'h0, 3'b010, v, rd, e, rdy);
      checks++;
      if (rd !== 32'hFEED1234 || v !== 1'b1) begin
         errors++;
         $display("FAIL mem_kept_over_reset: valid=%b rdata=%h, required 1 feed1234", v, rd);
      end
   endtask

   task automatic test_wait_states();
      logic rdy;
      req2(1'b1, 32'h40, 32'h11223344, 3'b010, rdy);
      repeat (3) @(posedge clk);
      req2(1'b0, 32'h40, 32'h0, 3'b010, rdy);
      checks++;
      if (rdy !== 1'b1 || bus2.req_ready !== 1'b0 || bus2.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_e0: ready_before=%b ready=%b valid=%b, required 1 0 0", rdy, bus2.req_ready, bus2.rsp_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus2.req_ready !== 1'b0 || bus2.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_e1: ready=%b valid=%b, required 0 0", bus2.req_ready, bus2.rsp_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus2.rsp_valid, bus2.rsp_err, bus2.req_ready} !== 3'b101 || bus2.rsp_rdata !== 32'h11223344) begin
         errors++;
         $display("FAIL wait_e2: valid=%b err=%b ready=%b rdata=%h, required 1 0 1 11223344",
                  bus2.rsp_valid, bus2.rsp_err, bus2.req_ready, bus2.rsp_rdata);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus2.rsp_valid !== 1'b0 || dbg2 !== 2'd0) begin
         errors++;
         $display("FAIL wait_e3: valid=%b state=%0d, required 0 0", bus2.rsp_valid, dbg2);
      end
   endtask

   task automatic test_wait_reset();
      logic rdy;
      logic seen;
      req2(1'b1, 32'h40, 32'hCAFEBABE, 3'b010, rdy);
      #2 rst_n2 = 1'b0;
      #2 rst_n2 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 if (bus2.rsp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || dbg2 !== 2'd0 || bus2.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_reset_abandon: pulse_seen=%b state=%0d ready=%b, required 0 0 1", seen, dbg2, bus2.req_ready);
      end
      req2(1'b0, 32'h40, 32'h0, 3'b010, rdy);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus2.rsp_valid !== 1'b1 || bus2.rsp_rdata !== 32'hCAFEBABE) begin
         errors++;
         $display("FAIL store_kept_after_abandon: valid=%b rdata=%h, required 1 cafebabe", bus2.rsp_valid, bus2.rsp_rdata);
      end
   endtask

   initial begin
      bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0;
      bus0.req_wdata = 32'd0; bus0.req_funct3 = 3'b010;
      bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'd0;
      bus2.req_wdata = 32'd0; bus2.req_funct3 = 3'b010;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_faults();
      test_async_reset();
      test_wait_states();
      test_wait_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
